cdb_arbiter: RTL and testbench

- Sits directly downstream of the execute stage. Receives the per-FU result buses (add, mul, div, br) and serialises them onto a single registered common data bus.
- The ROB, physical regfile and reservation stations consume that bus.
- Each FU has a small result FIFO, so simultaneous completions are never lost.
- Raises per-FU stall signals back to issue when that FU's FIFO is nearly full.
- Clears all queued results on a branch flush.

---
 rtl/rv32i_types.sv | 23 ++
 rtl/cdb_src_fifo.sv | 55 +++++
 rtl/cdb_arbiter.sv | 137 +++++++++++++
 tb/tb_cdb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types: the common data bus record plus the CDB arbiter
// source numbering and sizing defaults.
package rv32i_types;

   localparam int ROB_IDX_W = 6;
   localparam int PREG_W    = 6;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PREG_W-1:0]    pd_s;
      logic [31:0]          rd_v;
   } cdb_t;

   localparam int CDB_NUM_SRC    = 4;
   localparam int CDB_SRC_ADD    = 0;
   localparam int CDB_SRC_MUL    = 1;
   localparam int CDB_SRC_DIV    = 2;
   localparam int CDB_SRC_BR     = 3;
   localparam int CDB_FIFO_DEPTH = 4;
   localparam int CDB_SKID_SLOTS = 2;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO for the CDB arbiter. The head entry is presented
// combinationally so the arbiter can grant and pop it in the same cycle.
module cdb_src_fifo
   import rv32i_types::*;
#(
   parameter int DEPTH = CDB_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  cdb_t                     din,
   output cdb_t                     head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

   cdb_t             mem [DEPTH];
   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic [PTR_W:0]   count_reg;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push) tail_reg <= tail_reg + 1'b1;
         if (pop)  head_reg <= head_reg + 1'b1;
         if (push && !pop)
            count_reg <= count_reg + 1'b1;
         else if (pop && !push)
            count_reg <= count_reg - 1'b1;
      end
   end

   // When full with push and pop together, tail equals head: the old head is
   // read out this cycle and overwritten at the edge.
   always_ff @(posedge clk) begin
      if (push) mem[tail_reg] <= din;
   end

   assign head  = mem[head_reg];
   assign empty = (count_reg == '0);
   assign full  = (count_reg == FULL_CNT);
   assign count = count_reg;

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises per-FU results onto one registered common data bus with
// round-robin arbitration. Define CDB_ARB_BR_PRIORITY_EN to give br absolute priority.
module cdb_arbiter
   import rv32i_types::*;
#(
   parameter int NUM_SRC    = CDB_NUM_SRC,
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH,
   parameter int SKID_SLOTS = CDB_SKID_SLOTS
) (
   input  logic                       clk,
   input  logic                       rst,
   input  cdb_t                       cdb_in [NUM_SRC],
   input  logic                       global_branch_signal,
   output cdb_t                       cdb_out,
   output logic [$clog2(NUM_SRC)-1:0] grant_src,
   output logic [NUM_SRC-1:0]         stall_out,
   output logic                       overflow_err
);

   localparam int SRC_W    = $clog2(NUM_SRC);
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam int STALL_TH = FIFO_DEPTH - SKID_SLOTS;
   localparam logic [CNT_W-1:0] STALL_CNT = STALL_TH[CNT_W-1:0];

   cdb_t               fifo_head  [NUM_SRC];
   cdb_t               cand_entry [NUM_SRC];
   logic [CNT_W-1:0]   fifo_count [NUM_SRC];
   logic [NUM_SRC-1:0] fifo_empty, fifo_full;
   logic [NUM_SRC-1:0] cand, rr_cand, win_oh, bypass;
   logic [NUM_SRC-1:0] pop, push, enq_req, drop;

   logic               win_valid;
   logic [SRC_W-1:0]   win_idx;
   cdb_t               win_entry;
   logic [SRC_W-1:0]   rr_ptr_reg, rr_next;
   cdb_t               cdb_out_reg;
   logic [SRC_W-1:0]   grant_reg;
   logic               overflow_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[gi]),
            .pop   (pop[gi]),
            .flush (global_branch_signal),
            .din   (cdb_in[gi]),
            .head  (fifo_head[gi]),
            .empty (fifo_empty[gi]),
            .full  (fifo_full[gi]),
            .count (fifo_count[gi])
         );

         // Queued head beats the same-cycle input so per-source order holds.
         assign cand[gi]       = ~fifo_empty[gi] | cdb_in[gi].valid;
         assign cand_entry[gi] = fifo_empty[gi] ? cdb_in[gi] : fifo_head[gi];
         assign bypass[gi]     = win_oh[gi] & fifo_empty[gi];
         assign pop[gi]        = win_oh[gi] & ~fifo_empty[gi] & ~global_branch_signal;
         assign enq_req[gi]    = cdb_in[gi].valid & ~global_branch_signal & ~bypass[gi];
         assign push[gi]       = enq_req[gi] & (~fifo_full[gi] | pop[gi]);
         assign drop[gi]       = enq_req[gi] & fifo_full[gi] & ~pop[gi];
         assign stall_out[gi]  = (fifo_count[gi] >= STALL_CNT);
      end
   endgenerate

   always_comb begin
      rr_cand = cand;
`ifdef CDB_ARB_BR_PRIORITY_EN
      rr_cand[CDB_SRC_BR] = 1'b0;
`endif
   end

   always_comb begin
      int idx;
      win_valid = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int off = 0; off < NUM_SRC; off++) begin
         idx = int'(rr_ptr_reg) + off;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!win_valid && rr_cand[idx[SRC_W-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = idx[SRC_W-1:0];
         end
      end
`ifdef CDB_ARB_BR_PRIORITY_EN
      if (cand[CDB_SRC_BR]) begin
         win_valid = 1'b1;
         win_idx   = SRC_W'(CDB_SRC_BR);
      end
`endif
   end

   always_comb begin
      win_oh = '0;
      if (win_valid) win_oh[win_idx] = 1'b1;
      win_entry       = cand_entry[win_idx];
      win_entry.valid = 1'b1;
   end

   always_comb begin
      rr_next = rr_ptr_reg;
      if (win_valid)
         rr_next = (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
`ifdef CDB_ARB_BR_PRIORITY_EN
      if (win_valid && win_idx == SRC_W'(CDB_SRC_BR)) rr_next = rr_ptr_reg;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_out_reg  <= '0;
         grant_reg    <= '0;
         rr_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else if (global_branch_signal) begin
         cdb_out_reg <= '0;
         rr_ptr_reg  <= '0;
      end else begin
         if (win_valid) begin
            cdb_out_reg <= win_entry;
            grant_reg   <= win_idx;
         end else begin
            cdb_out_reg <= '0;
         end
         rr_ptr_reg <= rr_next;
         if (|drop) overflow_reg <= 1'b1;
      end
   end

   assign cdb_out      = cdb_out_reg;
   assign grant_src    = grant_reg;
   assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_cdb_arbiter;
   import rv32i_types::*;

   localparam int NS    = CDB_NUM_SRC;
   localparam int DEPTH = CDB_FIFO_DEPTH;
   localparam int SKID  = CDB_SKID_SLOTS;

   logic           clk = 1'b0;
   logic           rst;
   logic           global_branch_signal;
   cdb_t           cdb_in [NS];
   cdb_t           cdb_out;
   logic [1:0]     grant_src;
   logic [NS-1:0]  stall_out;
   logic           overflow_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk                  (clk),
      .rst                  (rst),
      .cdb_in               (cdb_in),
      .global_branch_signal (global_branch_signal),
      .cdb_out              (cdb_out),
      .grant_src            (grant_src),
      .stall_out            (stall_out),
      .overflow_err         (overflow_err)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Reference model: one queue per source, plain round-robin pointer.
   cdb_t          mq [NS][$];
   cdb_t          exp_out;
   int            exp_grant;
   logic [NS-1:0] exp_stall;
   logic          exp_ovf;
   int            m_rr;
   bit            model_on = 0;

   always @(posedge clk) begin
      int   w;
      bit   found;
      bit   byp;
      cdb_t ent;
      if (rst) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
         m_rr = 0; exp_out = '0; exp_grant = 0; exp_ovf = 1'b0; model_on = 1;
      end else if (global_branch_signal) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
         m_rr = 0; exp_out = '0;
      end else begin
         found = 0; w = 0; byp = 0;
`ifdef CDB_ARB_BR_PRIORITY_EN
         if (mq[CDB_SRC_BR].size() > 0 || cdb_in[CDB_SRC_BR].valid) begin
            found = 1; w = CDB_SRC_BR;
         end
`endif
         for (int k = 0; k < NS && !found; k++) begin
            int s;
            s = (m_rr + k) % NS;
`ifdef CDB_ARB_BR_PRIORITY_EN
            if (s == CDB_SRC_BR) continue;
`endif
            if (mq[s].size() > 0 || cdb_in[s].valid) begin
               found = 1; w = s;
            end
         end
         if (found) begin
            if (mq[w].size() > 0) ent = mq[w].pop_front();
            else begin ent = cdb_in[w]; byp = 1; end
            ent.valid = 1'b1;
            exp_out   = ent;
            exp_grant = w;
`ifdef CDB_ARB_BR_PRIORITY_EN
            if (w != CDB_SRC_BR) m_rr = (w + 1) % NS;
`else
            m_rr = (w + 1) % NS;
`endif
         end else begin
            exp_out = '0;
         end
         for (int i = 0; i < NS; i++) begin
            if (cdb_in[i].valid && !(byp && i == w)) begin
               if (mq[i].size() < DEPTH) mq[i].push_back(cdb_in[i]);
               else exp_ovf = 1'b1;
            end
         end
      end
      for (int i = 0; i < NS; i++) exp_stall[i] = (mq[i].size() >= DEPTH - SKID);
   end

   // Every-cycle comparison, plus a log of granted results for order checks.
   int obs_g[$];
   int obs_r[$];

   always @(negedge clk) begin
      if (model_on) begin
         check("cdb_out",   64'(cdb_out),      64'(exp_out));
         check("grant_src", 64'(grant_src),    64'(exp_grant));
         check("stall_out", 64'(stall_out),    64'(exp_stall));
         check("overflow",  64'(overflow_err), 64'(exp_ovf));
         if (cdb_out.valid) begin
            obs_g.push_back(int'(grant_src));
            obs_r.push_back(int'(cdb_out.rob_idx));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int s = 0; s < NS; s++) cdb_in[s] = '0;
   endtask

   task automatic drive(input int s, input int rob, input int pd, input logic [31:0] rd);
      cdb_in[s].valid   = 1'b1;
      cdb_in[s].rob_idx = ROB_IDX_W'(rob);
      cdb_in[s].pd_s    = PREG_W'(pd);
      cdb_in[s].rd_v    = rd;
   endtask

   cdb_t          e;
   logic [NS-1:0] stall_now, stall_prev;
   int            n1;
   int            sent1[$];
   int            src1_seen[$];
   bit            saw_stall;
   int            exp_seq [6];

   initial begin
      rst = 1'b1;
      global_branch_signal = 1'b0;
      idle();
      tick();
      tick();
      rst = 1'b0;

      // Idle after reset
      repeat (10) begin
         tick();
         check("idle", 64'({cdb_out.valid, stall_out, overflow_err}), 64'(0));
      end

      // Four simultaneous results from rr_ptr=0
      for (int s = 0; s < NS; s++) drive(s, s + 1, 8 + s, 32'h1000 + s);
      for (int k = 0; k < NS; k++) begin
         tick();
         if (k == 0) idle();
         check("four_seq", 64'({grant_src, cdb_out.valid, cdb_out.rob_idx}),
               64'({k[1:0], 1'b1, 6'(k + 1)}));
      end
      tick();
      check("four_done", 64'(cdb_out.valid), 64'(0));

      // rr_ptr back at 0: source 0 beats source 1
      drive(1, 7, 1, 32'h7);
      drive(0, 6, 0, 32'h6);
      tick();
      idle();
      check("rr_wrap_a", 64'({grant_src, cdb_out.rob_idx}), 64'({2'd0, 6'd6}));
      tick();
      check("rr_wrap_b", 64'({grant_src, cdb_out.rob_idx}), 64'({2'd1, 6'd7}));

      // Single uncontested add result
      drive(0, 5, 12, 32'hDEADBEEF);
      tick();
      idle();
      e.valid = 1'b1; e.rob_idx = 6'd5; e.pd_s = 6'd12; e.rd_v = 32'hDEADBEEF;
      check("add_fields", 64'(cdb_out), 64'(e));
      check("add_grant",  64'(grant_src), 64'(0));
      tick();
      check("add_after",  64'(cdb_out.valid), 64'(0));

      // Back-pressure, driver honours stall one cycle late
      stall_now = '0; stall_prev = '0; n1 = 0; saw_stall = 0;
      obs_g.delete(); obs_r.delete();
      for (int c = 0; c < 16; c++) begin
         for (int s = 0; s < NS; s++) begin
            if (stall_prev[s]) cdb_in[s] = '0;
            else if (s == 1) begin
               drive(1, 10 + n1, 1, 32'(n1));
               sent1.push_back(10 + n1);
               n1++;
            end else drive(s, 40 + s, s, 32'(c));
         end
         tick();
         if (stall_out[1]) saw_stall = 1;
         stall_prev = stall_now;
         stall_now  = stall_out;
      end
      idle();
      repeat (20) tick();
      check("bp_stall_seen", 64'(saw_stall), 64'(1));
      check("bp_no_ovf",     64'(overflow_err), 64'(0));
      for (int i = 0; i < obs_g.size(); i++)
         if (obs_g[i] == 1) src1_seen.push_back(obs_r[i]);
      check("bp_src1_count", 64'(src1_seen.size()), 64'(sent1.size()));
      for (int i = 0; i < sent1.size() && i < src1_seen.size(); i++)
         check("bp_src1_order", 64'(src1_seen[i]), 64'(sent1[i]));

      // Fill FIFOs 0 and 2 to three entries, then flush
      for (int c = 0; c < 6; c++) begin
         drive(0, 50 + c, 0, 32'(c));
         drive(2, 56 + c, 2, 32'(c));
         tick();
      end
      check("prefill_stall", 64'(stall_out), 64'(4'b0101));
      for (int s = 0; s < NS; s++) drive(s, 30, s, 32'hBAD);
      global_branch_signal = 1'b1;
      tick();
      global_branch_signal = 1'b0;
      idle();
      check("flush_out", 64'({cdb_out.valid, stall_out}), 64'(0));
      tick();
      check("flush_empty", 64'({cdb_out.valid, stall_out}), 64'(0));
      drive(0, 9, 3, 32'h99);
      tick();
      idle();
      check("post_flush", 64'({grant_src, cdb_out.valid, cdb_out.rob_idx}),
            64'({2'd0, 1'b1, 6'd9}));
      tick();
      check("post_flush_after", 64'(cdb_out.valid), 64'(0));

      // br vs add contention from rr_ptr=0
      global_branch_signal = 1'b1;
      tick();
      global_branch_signal = 1'b0;
      obs_g.delete(); obs_r.delete();
      for (int c = 0; c < 3; c++) begin
         drive(0, 20 + c, 0, 32'(c));
         drive(3, 30 + c, 3, 32'(c));
         tick();
      end
      idle();
      repeat (8) tick();
`ifdef CDB_ARB_BR_PRIORITY_EN
      exp_seq = '{30, 31, 32, 20, 21, 22};
`else
      exp_seq = '{20, 30, 21, 31, 22, 32};
`endif
      check("br_count", 64'(obs_r.size()), 64'(6));
      for (int i = 0; i < 6 && i < obs_r.size(); i++)
         check("br_order", 64'(obs_r[i]), 64'(exp_seq[i]));

      // Overflow: ignore stall, sticky across flush, cleared by reset
      for (int c = 0; c < 8; c++) begin
         for (int s = 0; s < NS; s++) drive(s, 8 * s + c, s, 32'(c));
         tick();
      end
      idle();
      tick();
      check("ovf_set", 64'(overflow_err), 64'(1));
      global_branch_signal = 1'b1;
      tick();
      global_branch_signal = 1'b0;
      check("ovf_flush", 64'({overflow_err, cdb_out.valid, stall_out}), 64'({1'b1, 1'b0, 4'b0}));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ovf_reset", 64'({overflow_err, cdb_out.valid, stall_out, grant_src}), 64'(0));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
